// File: rtl/imem_loader.sv
// Writable instruction memory with a byte-stream loader; fetch data is registered (1 cycle), a load takes 5 cycles/word.
// byte_ready is high only in RECV and never depends on byte_valid; IMEM_HALT_DETECT_EN enables halt-word termination.
module imem_loader #(
  parameter int          SIZE       = 64,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] HALT_WORD  = 32'hB4221820
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic                    byte_ready,
  input  logic [31:0]             address,
  output logic [DATA_WIDTH-1:0]   inst_out,
  output logic                    cpu_hold,
  output logic                    load_done,
  output logic [$clog2(SIZE):0]   word_count,
  output logic                    overflow
);
  localparam int AW = $clog2(SIZE);
`ifdef IMEM_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] word;
  logic [AW-1:0]         wptr;
  logic [1:0]            bcnt;
  logic                  is_halt;
  logic                  at_last;
  logic                  in_range;
  logic                  unused_addr;
  logic [DATA_WIDTH-1:0] mem [SIZE];

  assign is_halt     = HALT_EN && (word == HALT_WORD);
  assign at_last     = (wptr == AW'(SIZE - 1));
  assign in_range    = (address[31:2] < 30'(SIZE));
  assign unused_addr = ^address[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RECV;
      end
      RECV: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid && bcnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        cpu_hold = 1'b1;
        if (is_halt || at_last) state_nxt = DONE;
        else                    state_nxt = RECV;
      end
      DONE: begin
        cpu_hold  = 1'b1;
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Loader datapath: byte assembly, write pointer and load status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word       <= '0;
      wptr       <= '0;
      bcnt       <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wptr       <= '0;
            bcnt       <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
          end
        end
        RECV: begin
          if (byte_valid) begin
            word <= {word[DATA_WIDTH-9:0], byte_data};
            bcnt <= bcnt + 2'd1;
          end
        end
        WRITE: begin
          word_count <= word_count + (AW+1)'(1);
          if (!is_halt) begin
            if (at_last) overflow <= HALT_EN;
            else         wptr     <= wptr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory contents survive reset so a partially completed load keeps its written words.
  always_ff @(posedge clk) begin
    if (state == WRITE) mem[wptr] <= word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         inst_out <= '0;
    else if (cpu_hold)  inst_out <= '0;
    else if (!in_range) inst_out <= '0;
    else                inst_out <= mem[address[AW+1:2]];
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 64-word instance for program loads and a 4-word instance for the overflow table.
module tb_imem_loader;
`ifdef IMEM_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, byte_valid, byte_ready, cpu_hold, load_done, overflow;
  logic [7:0]  byte_data;
  logic [31:0] address, inst_out;
  logic [6:0]  word_count;

  logic        s_start, s_bv, s_byte_ready, s_cpu_hold, s_load_done, s_overflow;
  logic [7:0]  s_bd;
  logic [31:0] s_address, s_inst_out;
  logic [2:0]  s_word_count;

  int tests = 0;
  int fails = 0;

  imem_loader #(.SIZE(64)) u_dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .address(address), .inst_out(inst_out), .cpu_hold(cpu_hold),
    .load_done(load_done), .word_count(word_count), .overflow(overflow)
  );

  imem_loader #(.SIZE(4)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .byte_valid(s_bv), .byte_data(s_bd),
    .byte_ready(s_byte_ready), .address(s_address), .inst_out(s_inst_out), .cpu_hold(s_cpu_hold),
    .load_done(s_load_done), .word_count(s_word_count), .overflow(s_overflow)
  );

  typedef struct {
    logic       st;
    logic       bv;
    logic [7:0] bd;
    logic       rdy;
    logic       hold;
    logic       done;
    logic       ovf;
    logic [2:0] wc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } fvec_t;

  vec_t       vt[$];
  fvec_t      ft[$];
  logic [7:0] q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic st, input logic bv, input logic [7:0] bd, input logic rdy,
                                  input logic hold, input logic done, input logic ovf, input logic [2:0] wc);
    vec_t v;
    v.st = st; v.bv = bv; v.bd = bd; v.rdy = rdy; v.hold = hold; v.done = done; v.ovf = ovf; v.wc = wc;
    vt.push_back(v);
  endfunction

  function automatic void add_fetch(input logic [31:0] a, input logic [31:0] e);
    fvec_t f;
    f.addr = a; f.exp = e;
    ft.push_back(f);
  endfunction

  // Called right after a negedge; returns right after the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int n = 0; n < 20 && !acc; n++) begin
      acc = byte_ready;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (!acc) begin
      fails++;
      $display("FAIL send_byte timeout: byte %h never accepted", b);
    end
  endtask

  task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] e);
    address = a;
    @(negedge clk);
    check(name, inst_out, e);
  endtask

  task automatic run_load(input string tag, input int gap);
    int  done_cnt = 0;
    bit  hold_bad = 1'b0;
    bit  inst_bad = 1'b0;
    bit  finished = 1'b0;
    bit  acc, hold_s;
    q.delete();
    q.push_back(8'h8C); q.push_back(8'h01); q.push_back(8'h00); q.push_back(8'h00);
    q.push_back(8'hB4); q.push_back(8'h22); q.push_back(8'h18); q.push_back(8'h20);
    for (int w = 2; w < 64; w++) begin
      q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h20);
    end
    address = 32'h0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      byte_valid = (q.size() > 0) && (cyc % gap == 0);
      byte_data  = byte_valid ? q[0] : 8'h00;
      acc    = byte_valid && byte_ready;
      hold_s = cpu_hold;
      @(negedge clk);
      if (acc) void'(q.pop_front());
      if (hold_s && inst_out !== 32'h0) inst_bad = 1'b1;
      if (load_done) begin
        done_cnt++;
        finished = 1'b1;
      end else if (!cpu_hold) hold_bad = 1'b1;
    end
    byte_valid = 1'b0;
    check({tag, "_finished"}, finished, 1'b1);
    check({tag, "_word_count"}, word_count, HALT_EN ? 7'd2 : 7'd64);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_hold_throughout"}, hold_bad, 1'b0);
    check({tag, "_nop_while_held"}, inst_bad, 1'b0);
    @(negedge clk);
    check({tag, "_hold_released"}, {cpu_hold, load_done}, 2'b00);
    repeat (3) begin
      @(negedge clk);
      if (load_done) done_cnt++;
    end
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    // 4-word instance: four 00000020 words fill memory; start pulsed mid-load must be ignored.
    add_vec(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++)
        add_vec(w == 2 && b == 1, 1'b1, (b == 3) ? 8'h20 : 8'h00, b < 3, 1'b1, 1'b0, 1'b0, 3'(w));
      add_vec(1'b0, 1'b1, 8'h00, w < 3, 1'b1, w == 3, (w == 3) && HALT_EN, 3'(w + 1));
    end
    add_vec(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, HALT_EN, 3'd4);
    add_vec(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, HALT_EN, 3'd4);
    add_vec(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, HALT_EN, 3'd4);

    add_fetch(32'h0000_0000, 32'h0000_0020);
    add_fetch(32'h0000_0004, 32'h0000_0020);
    add_fetch(32'h0000_0008, 32'h0000_0020);
    add_fetch(32'h0000_000C, 32'h0000_0020);
    add_fetch(32'h0000_0010, 32'h0000_0000);
    add_fetch(32'h0000_0003, 32'h0000_0020);
    add_fetch(32'h8000_0000, 32'h0000_0000);

    reset = 1'b0; start = 1'b1; byte_valid = 1'b1; byte_data = 8'h8C; address = 32'h0;
    s_start = 1'b1; s_bv = 1'b1; s_bd = 8'h8C; s_address = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {byte_ready, cpu_hold, load_done, overflow, word_count, inst_out}, '0);
    check("reset_outputs_small", {s_byte_ready, s_cpu_hold, s_load_done, s_overflow, s_word_count, s_inst_out}, '0);
    start = 1'b0; s_start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {byte_ready, cpu_hold, s_byte_ready, s_cpu_hold}, 4'b0000);
    byte_valid = 1'b0; s_bv = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      s_start = vt[i].st; s_bv = vt[i].bv; s_bd = vt[i].bd;
      @(negedge clk);
      check($sformatf("small_vec%0d", i), {s_byte_ready, s_cpu_hold, s_load_done, s_overflow, s_word_count},
            {vt[i].rdy, vt[i].hold, vt[i].done, vt[i].ovf, vt[i].wc});
    end
    s_start = 1'b0; s_bv = 1'b0;
    for (int i = 0; i < ft.size(); i++) begin
      s_address = ft[i].addr;
      @(negedge clk);
      check($sformatf("small_fetch%0d", i), s_inst_out, ft[i].exp);
    end

    run_load("load_full_rate", 1);
    fetch("fetch_w0", 32'h0, 32'h8C01_0000);
    fetch("fetch_w1_latency", 32'h5, 32'hB422_1820);
    fetch("fetch_out_of_range", 32'h100, 32'h0);

    // Abort a load after 6 bytes: the first word stays written, the second never lands.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    reset = 1'b0;
    #1;
    check("midload_reset_outputs", {byte_ready, cpu_hold, load_done, overflow, word_count, inst_out}, '0);
    @(negedge clk);
    reset = 1'b1;
    byte_valid = 1'b1; byte_data = 8'h55;
    repeat (3) @(negedge clk);
    check("midload_reset_idle", {byte_ready, cpu_hold}, 2'b00);
    byte_valid = 1'b0;
    fetch("midload_w0_kept", 32'h0, 32'h2008_0000);
    fetch("midload_w1_untouched", 32'h4, 32'hB422_1820);

    run_load("load_throttled", 3);
    fetch("throttled_w0", 32'h0, 32'h8C01_0000);
    fetch("throttled_w1", 32'h4, 32'hB422_1820);

    // A start pulse while receiving must not rewind the write pointer.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    @(negedge clk);
    check("start_in_recv_word_count", word_count, 7'd2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fetch("start_in_recv_w0", 32'h0, 32'h1122_3344);
    fetch("start_in_recv_w1", 32'h4, 32'h5566_7788);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
